// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-seeding PRBS/LFSR receive checker with lock, error pulse and saturating count
// Seeds from the first W valid bits, then predicts every following bit from its own state.
module prbs_checker #(
  parameter int unsigned    W           = 7,
  parameter logic [W-1:0]   TAPS        = 7'b1100000,
  parameter int unsigned    WIN_LEN     = 64,
  parameter int unsigned    LOSS_THRESH = 8,
  parameter int unsigned    CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             state_dbg
);

  localparam int unsigned SEED_W = $clog2(W + 1);
  localparam int unsigned WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned ERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t            state;
  logic [W-1:0]      sr;
  logic [SEED_W-1:0] seed_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  win_err;

  logic              pred;
  logic              mismatch;
  logic [W-1:0]      seed_sr;
  logic [ERR_W-1:0]  win_err_next;
  logic              seed_done;
  logic              loss;
  logic              win_end;

  // win_err never exceeds LOSS_THRESH-1 between bits, so win_err_next cannot overflow ERR_W.
  always_comb begin
    pred         = ^(sr & TAPS);
    mismatch     = bit_in ^ pred;
    seed_sr      = {sr[W-2:0], bit_in};
    seed_done    = (seed_cnt == SEED_W'(W - 1));
    win_err_next = win_err + ERR_W'(mismatch);
    loss         = (win_err_next >= ERR_W'(LOSS_THRESH));
    win_end      = (win_cnt == WIN_W'(WIN_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_valid) begin
        case (state)
          SEED: begin
            sr <= seed_sr;
            if (seed_done) begin
              seed_cnt <= '0;
              if (|seed_sr) begin
                state   <= CHECK;
                locked  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + SEED_W'(1);
            end
          end
          CHECK: begin
            err_pulse <= mismatch;
            if (mismatch && !(&err_count)) begin
              err_count <= err_count + CNT_W'(1);
            end
            // Loss outranks the window rollover; the predicted bit keeps a single line error from propagating.
            if (loss) begin
              state    <= SEED;
              locked   <= 1'b0;
              sr       <= '0;
              seed_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else begin
              sr <= {sr[W-2:0], pred};
              if (win_end) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                win_err <= win_err_next;
              end
            end
          end
          default: state <= SEED;
        endcase
      end
      if (clr_cnt) begin
        err_count <= '0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed scoreboard bench for prbs_checker (default and 4-bit counter instances)
module tb_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rst_s = 1'b1;
  logic        bit_in = 1'b0, bit_valid = 1'b0;
  logic        clr_cnt = 1'b0, clr_cnt_s = 1'b0;
  logic        locked, err_pulse, state_dbg;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s, state_dbg_s;
  logic [3:0]  err_count_s;

  prbs_checker dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_dbg(state_dbg)
  );

  prbs_checker #(.W(7), .TAPS(7'b1100000), .WIN_LEN(64), .LOSS_THRESH(64), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst_s), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt_s),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .state_dbg(state_dbg_s)
  );

  typedef struct {
    logic        locked;
    logic        pulse;
    logic [15:0] count;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  bit   sel      = 1'b0;

  // Reference behaviour of the receiver, driven by which bits the bench deliberately inverted.
  logic       m_locked;
  int         m_seed_cnt, m_win_cnt, m_win_err, m_count;
  int         m_max    = 65535;
  int         m_thresh = 8;
  logic [6:0] m_seed_sr;
  logic [6:0] gen_sr = 7'h7f;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_seed_cnt = 0;
    m_seed_sr  = '0;
    m_win_cnt  = 0;
    m_win_err  = 0;
    m_count    = 0;
  endtask

  task automatic model_edge(input logic v, input logic b, input logic mism, input logic clr, output exp_t e);
    e.pulse = 1'b0;
    if (v) begin
      if (!m_locked) begin
        m_seed_sr = {m_seed_sr[5:0], b};
        if (m_seed_cnt == 6) begin
          m_seed_cnt = 0;
          if (m_seed_sr != 7'd0) begin
            m_locked  = 1'b1;
            m_win_cnt = 0;
            m_win_err = 0;
          end
        end else begin
          m_seed_cnt++;
        end
      end else begin
        e.pulse = mism;
        if (mism && m_count != m_max) m_count++;
        if (m_win_err + int'(mism) >= m_thresh) begin
          m_locked   = 1'b0;
          m_seed_sr  = '0;
          m_seed_cnt = 0;
          m_win_cnt  = 0;
          m_win_err  = 0;
        end else if (m_win_cnt == 63) begin
          m_win_cnt = 0;
          m_win_err = 0;
        end else begin
          m_win_cnt++;
          m_win_err += int'(mism);
        end
      end
    end
    if (clr) m_count = 0;
    e.locked = m_locked;
    e.count  = 16'(m_count);
  endtask

  task automatic step(input logic v, input logic b, input logic mism, input logic clr);
    exp_t e;
    bit_valid = v;
    bit_in    = b;
    clr_cnt   = sel ? 1'b0 : clr;
    clr_cnt_s = sel ? clr : 1'b0;
    model_edge(v, b, mism, clr, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    e = q.pop_front();
    chk("locked", {15'd0, sel ? locked_s : locked}, {15'd0, e.locked});
    chk("state_dbg", {15'd0, sel ? state_dbg_s : state_dbg}, {15'd0, e.locked});
    chk("err_pulse", {15'd0, sel ? err_pulse_s : err_pulse}, {15'd0, e.pulse});
    chk("err_count", sel ? {12'd0, err_count_s} : err_count, e.count);
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    clr_cnt_s = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    if (sel) rst_s = 1'b1; else rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit_valid = ~bit_valid;
      bit_in    = 1'($urandom);
      @(posedge clk);
      #1;
      step_no++;
      chk("rst_locked", {15'd0, sel ? locked_s : locked}, 16'd0);
      chk("rst_pulse", {15'd0, sel ? err_pulse_s : err_pulse}, 16'd0);
      chk("rst_count", sel ? {12'd0, err_count_s} : err_count, 16'd0);
      chk("rst_state", {15'd0, sel ? state_dbg_s : state_dbg}, 16'd0);
    end
    bit_valid = 1'b0;
    if (sel) rst_s = 1'b0; else rst = 1'b0;
    model_reset();
  endtask

  task automatic gen_bit(input logic flip, input logic clr);
    logic b;
    b      = gen_sr[6] ^ gen_sr[5];
    gen_sr = {gen_sr[5:0], b};
    step(1'b1, b ^ flip, flip, clr);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic seed_ones();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    gen_sr = 7'h7f;
  endtask

  initial begin
    // Reset held with bit_valid toggling
    reset_cycles(3);

    // Clean lock and 200 correct bits with random gaps
    seed_ones();
    for (int i = 0; i < 200; i++) begin
      gen_bit(1'b0, 1'b0);
      gap($urandom_range(0, 3));
    end

    // Single inverted check bit, then a lone counter clear
    for (int i = 0; i < 49; i++) gen_bit(1'b0, 1'b0);
    gen_bit(1'b1, 1'b0);
    gen_bit(1'b0, 1'b0);
    gap(1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Eight errors in one window force loss, then relock on the correct stream
    for (int i = 0; i < 70 && m_win_cnt != 0; i++) gen_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      gen_bit(1'b1, 1'b0);
      gen_bit(1'b0, 1'b0);
    end
    for (int i = 0; i < 30; i++) gen_bit(1'b0, 1'b0);

    // Degenerate all-zero seed, real seed, then a mid-stream reset and reseed
    reset_cycles(1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    gap(2);
    seed_ones();
    for (int i = 0; i < 30; i++) gen_bit(1'b0, 1'b0);
    reset_cycles(1);
    for (int i = 0; i < 20; i++) gen_bit(1'b0, 1'b0);

    // 4-bit counter instance: saturation and clear coincident with an error
    rst      = 1'b1;
    sel      = 1'b1;
    m_max    = 15;
    m_thresh = 64;
    reset_cycles(2);
    seed_ones();
    for (int i = 0; i < 20; i++) begin
      gen_bit(1'b1, 1'b0);
      for (int j = 0; j < 4; j++) gen_bit(1'b0, 1'b0);
    end
    gen_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) gen_bit(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
